load_aligner: RTL

- Memory-side load stage that feeds the extender: accepts a load request (address, Sign, Byte), fetches the aligned 32-bit word over a request/acknowledge handshake, and selects the addressed byte or halfword lane.
- Presents D[15:0] with matching ExtSign/ExtByte controls, qualified by a one-cycle Valid, directly to the extender's D/Sign/Byte inputs.
- Flags misaligned halfword loads and memory timeouts.

---
 rtl/load_aligner.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/load_aligner.sv
// load_aligner
//   Memory-side load stage feeding the extender. Accepts a load request
//   (address, Sign, Byte) and fetches the aligned 32-bit word over a
//   MemReq/MemAck handshake. It selects the addressed byte or halfword lane
//   and presents it on D, with ExtSign/ExtByte, qualified by a one-cycle Valid.
//   Misaligned halfword loads and memory timeouts raise a one-cycle Err.
//
// Parameters
//   TIMEOUT : max cycles MemReq stays high without MemAck (2..255)
//   CNT_W   : wait counter width, must hold TIMEOUT-1
//
// Ports
//   Clk, Rst_n        : clock, synchronous active-low reset
//   Start             : request strobe, accepted only in IDLE
//   Addr, Sign, Byte  : load address, signed flag, byte(1)/halfword(0)
//   MemReq, MemAddr   : memory read request and word-aligned address
//   MemRdata, MemAck  : read data and completion from memory
//   D, ExtSign, ExtByte : selected lane and controls to the extender
//   Valid             : one-cycle pulse, D/ExtSign/ExtByte meaningful
//   Busy              : high in every state except IDLE
//   Err               : one-cycle pulse on misalignment or timeout
//
// Build option
//   LOAD_BIG_ENDIAN_EN : when defined, lanes are selected big-endian.
//                        Timing is identical in both builds.
module load_aligner #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [31:0] Addr,
  input  logic        Sign,
  input  logic        Byte,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic [31:0] MemRdata,
  input  logic        MemAck,
  output logic [15:0] D,
  output logic        ExtSign,
  output logic        ExtByte,
  output logic        Valid,
  output logic        Busy,
  output logic        Err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [29:0]      word_addr_q, word_addr_d;
  logic [1:0]       lane_q, lane_d;
  logic             req_sign_q, req_sign_d;
  logic             req_byte_q, req_byte_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      d_q, d_d;
  logic             ext_sign_q, ext_sign_d;
  logic             ext_byte_q, ext_byte_d;

  // Picks the addressed lane out of the fetched word. Halfword requests
  // only arrive here with lane[0]==0, so lane[1] alone picks the half.
  function automatic logic [15:0] lane_sel(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic        is_byte);
    logic [7:0] b;
`ifdef LOAD_BIG_ENDIAN_EN
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    if (is_byte) return {8'h00, b};
    return lane[1] ? word[15:0] : word[31:16];
`else
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    if (is_byte) return {8'h00, b};
    return lane[1] ? word[31:16] : word[15:0];
`endif
  endfunction

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    lane_d      = lane_q;
    req_sign_d  = req_sign_q;
    req_byte_d  = req_byte_q;
    cnt_d       = cnt_q;
    d_d         = d_q;
    ext_sign_d  = ext_sign_q;
    ext_byte_d  = ext_byte_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          word_addr_d = Addr[31:2];
          lane_d      = Addr[1:0];
          req_sign_d  = Sign;
          req_byte_d  = Byte;
          cnt_d       = '0;
          // Misaligned halfword aborts without ever touching memory.
          state_d     = (!Byte && Addr[0]) ? S_ERR : S_WAIT;
        end
      end
      S_WAIT: begin
        // An acknowledge in the last allowed cycle still completes the load.
        if (MemAck) begin
          d_d        = lane_sel(MemRdata, lane_q, req_byte_q);
          ext_sign_d = req_sign_q;
          ext_byte_d = req_byte_q;
          state_d    = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      word_addr_q <= '0;
      lane_q      <= '0;
      req_sign_q  <= 1'b0;
      req_byte_q  <= 1'b0;
      cnt_q       <= '0;
      d_q         <= '0;
      ext_sign_q  <= 1'b0;
      ext_byte_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      lane_q      <= lane_d;
      req_sign_q  <= req_sign_d;
      req_byte_q  <= req_byte_d;
      cnt_q       <= cnt_d;
      d_q         <= d_d;
      ext_sign_q  <= ext_sign_d;
      ext_byte_q  <= ext_byte_d;
    end
  end

  assign MemReq  = (state_q == S_WAIT);
  assign MemAddr = {word_addr_q, 2'b00};
  assign D       = d_q;
  assign ExtSign = ext_sign_q;
  assign ExtByte = ext_byte_q;
  assign Valid   = (state_q == S_DONE);
  assign Err     = (state_q == S_ERR);
  assign Busy    = (state_q != S_IDLE);

endmodule
